// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle ALU with persistent Z/C/N/V flags and an iterative shift-add multiplier
//   clk, rst                       clock, async active-high reset
//   in_valid / in_ready            operand handshake (opcode, a, b)
//   out_valid                      one-cycle pulse when result/flags update
//   result, result_hi              registered low/high result (high half nonzero only for mul)
//   flag_z, flag_c, flag_n, flag_v registered flags
module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, MUL} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, mcand, acc_n;
    logic [WIDTH-1:0] mplier, res;
    logic [WIDTH:0] sum, dif;
    logic cin, c_n, v_n;
    assign in_ready = (state == IDLE) && !rst;
    always_comb begin
        cin = (opcode == 4'd8 || opcode == 4'd9) ? flag_c : 1'b0;
        sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        dif = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
        acc_n = acc + (mplier[0] ? mcand : '0);
        res = '0;
        c_n = flag_c;
        v_n = 1'b0;
        case (opcode)
            4'd0, 4'd8: begin
                res = sum[WIDTH-1:0];
                c_n = sum[WIDTH];
                v_n = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            // bit WIDTH of the widened difference is the borrow
            4'd1, 4'd9, 4'd14: begin
                res = dif[WIDTH-1:0];
                c_n = dif[WIDTH];
                v_n = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ~a;
            4'd6: begin res = {a[WIDTH-2:0], 1'b0}; c_n = a[WIDTH-1]; end
            4'd7: begin res = {1'b0, a[WIDTH-1:1]}; c_n = a[0]; end
            4'd10: begin res = {a[WIDTH-1], a[WIDTH-1:1]}; c_n = a[0]; end
            4'd11: begin res = {a[WIDTH-2:0], a[WIDTH-1]}; c_n = a[WIDTH-1]; end
            4'd12: begin res = {a[0], a[WIDTH-1:1]}; c_n = a[0]; end
            4'd15: res = b;
            default: res = '0;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            result <= '0;
            result_hi <= '0;
            {flag_z, flag_c, flag_n, flag_v} <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    if (opcode == 4'd13) begin
                        mcand <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc <= '0;
                        cnt <= '0;
                        state <= MUL;
                    end else begin
                        out_valid <= 1'b1;
                        flag_z <= res == '0;
                        flag_n <= res[WIDTH-1];
                        flag_c <= c_n;
                        flag_v <= v_n;
                        // cmp only touches flags
                        if (opcode != 4'd14) begin
                            result <= res;
                            result_hi <= '0;
                        end
                    end
                end
            end else begin
                acc <= acc_n;
                mcand <= mcand << 1;
                mplier <= mplier >> 1;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(WIDTH-1)) begin
                    result <= acc_n[WIDTH-1:0];
                    result_hi <= acc_n[2*WIDTH-1:WIDTH];
                    flag_c <= |acc_n[2*WIDTH-1:WIDTH];
                    flag_z <= acc_n == '0;
                    flag_n <= acc_n[2*WIDTH-1];
                    flag_v <= 1'b0;
                    out_valid <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed-vector bench for alu_multicycle at WIDTH=8
module tb_alu_multicycle;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready, out_valid;
    logic [3:0] opcode = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [7:0] result, result_hi;
    logic flag_z, flag_c, flag_n, flag_v;
    logic [3:0] zcnv;
    int n_vec = 0;
    int n_bad = 0;
    assign zcnv = {flag_z, flag_c, flag_n, flag_v};
    alu_multicycle #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .out_valid(out_valid),
        .result(result), .result_hi(result_hi),
        .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .flag_v(flag_v)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // present one op, wait for its accept edge, check the completion cycle
    task automatic op(input string tag, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] er, input logic [3:0] ef);
        in_valid = 1'b1;
        opcode = o;
        a = x;
        b = y;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk({tag, " valid"}, 32'(out_valid), 1);
        chk({tag, " result"}, 32'(result), 32'(er));
        chk({tag, " flags"}, 32'(zcnv), 32'(ef));
    endtask
    initial begin
        int seen;
        #2;
        chk("rst result", 32'(result), 0);
        chk("rst result_hi", 32'(result_hi), 0);
        chk("rst flags", 32'(zcnv), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst in_ready", 32'(in_ready), 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post-rst in_ready", 32'(in_ready), 1);
        chk("post-rst out_valid", 32'(out_valid), 0);
        op("add", 4'd0, 8'hFF, 8'h01, 8'h00, 4'b1100);
        op("adc", 4'd8, 8'h10, 8'h20, 8'h31, 4'b0000);
        op("sbc", 4'd9, 8'h05, 8'h05, 8'h00, 4'b1000);
        op("sub ovf", 4'd1, 8'h80, 8'h01, 8'h7F, 4'b0001);
        op("sub borrow", 4'd1, 8'h01, 8'h02, 8'hFF, 4'b0110);
        @(posedge clk);
        #1;
        chk("idle out_valid", 32'(out_valid), 0);
        chk("idle hold", 32'(result), 32'hFF);
        in_valid = 1'b1;
        opcode = 4'd13;
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        #1;
        opcode = 4'd0;
        a = 8'h03;
        b = 8'h04;
        for (int i = 0; i < 8; i++) begin
            chk("mul busy in_ready", 32'(in_ready), 0);
            chk("mul busy out_valid", 32'(out_valid), 0);
            @(posedge clk);
            #1;
        end
        chk("mul valid", 32'(out_valid), 1);
        chk("mul in_ready", 32'(in_ready), 1);
        chk("mul result", 32'(result), 32'h01);
        chk("mul result_hi", 32'(result_hi), 32'hFE);
        chk("mul flags", 32'(zcnv), 32'b0110);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("held add valid", 32'(out_valid), 1);
        chk("held add result", 32'(result), 32'h07);
        chk("held add result_hi", 32'(result_hi), 0);
        chk("held add flags", 32'(zcnv), 0);
        op("and", 4'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000);
        op("or", 4'd3, 8'h0F, 8'h30, 8'h3F, 4'b0000);
        op("xor", 4'd4, 8'hFF, 8'h0F, 8'hF0, 4'b0010);
        op("asr", 4'd10, 8'h81, 8'h00, 8'hC0, 4'b0110);
        op("rol", 4'd11, 8'h81, 8'h00, 8'h03, 4'b0100);
        op("cmp", 4'd14, 8'h22, 8'h22, 8'h03, 4'b1000);
        op("not", 4'd5, 8'h0F, 8'h00, 8'hF0, 4'b0010);
        op("shr", 4'd7, 8'h01, 8'h00, 8'h00, 4'b1100);
        op("ror", 4'd12, 8'h01, 8'h00, 8'h80, 4'b0110);
        op("shl", 4'd6, 8'h80, 8'h00, 8'h00, 4'b1100);
        op("passb", 4'd15, 8'h00, 8'h5A, 8'h5A, 4'b0100);
        in_valid = 1'b1;
        opcode = 4'd13;
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midmul rst result", 32'(result), 0);
        chk("midmul rst result_hi", 32'(result_hi), 0);
        chk("midmul rst flags", 32'(zcnv), 0);
        chk("midmul rst out_valid", 32'(out_valid), 0);
        chk("midmul rst in_ready", 32'(in_ready), 0);
        #2 rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abandoned mul out_valid", 32'(seen), 0);
        op("add after rst", 4'd0, 8'h01, 8'h01, 8'h02, 4'b0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised multi-cycle ALU for the ProtoCore datapath. It keeps the original eight operations and adds:
- carry-in arithmetic (adc/sbc), arithmetic shift, rotates, compare, and an iterative WIDTH×WIDTH multiply;
- persistent registered flags (Z, C, N, V) that feed the carry chain between instructions;
- a valid/ready operand handshake and a registered single-cycle result pulse.

It sits between the register file read ports and the writeback/flag logic.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and opcode presented.
- in_ready  out  1  block can accept an operation this cycle.
- opcode  in  4  operation select (see Operation).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  one-cycle pulse: result/flags just updated.
- result  out  WIDTH  low result, registered.
- result_hi  out  WIDTH  multiply high half, registered; 0 for all other ops.
- flag_z, flag_c, flag_n, flag_v  out  1 each  registered zero/carry/negative/overflow.

## Operation
- **Opcodes**
  - 0 add: a+b.
  - 1 sub: a−b.
  - 2 and. 3 or. 4 xor.
  - 5 not: ~a.
  - 6 shl: a<<1.
  - 7 shr: logical a>>1.
  - 8 adc: a+b+C.
  - 9 sbc: a−b−C.
  - 10 asr: a>>1, MSB replicated.
  - 11 rol: rotate a left 1.
  - 12 ror: rotate a right 1.
  - 13 mul: unsigned a×b.
  - 14 cmp: a−b, flags only.
  - 15 passb: b.
- **Arithmetic**: computed at WIDTH+1 bits, so the carry bit is the natural bit WIDTH.
- **flag_c**
  - add/adc: carry-out.
  - sub/sbc/cmp: borrow, i.e. 1 when the unsigned minuend is less than the subtrahend (including C for sbc).
  - shl/rol: old a[WIDTH−1].
  - shr/asr/ror: old a[0].
  - mul: 1 iff result_hi≠0.
  - and/or/xor/not/passb: C unchanged.
- **flag_v**: signed overflow for add/adc/sub/sbc/cmp; cleared by every other op.
- **flag_n**: MSB of the value written, or of a−b for cmp. For mul it is MSB of result_hi.
- **flag_z**: written value == 0. For mul, 1 iff both halves are 0. For cmp, (a−b)==0.
- **cmp**: updates all four flags; result and result_hi hold their previous values.
- Flags change only on the completion edge of an operation. Between operations they hold.
- **FSM states: IDLE, MUL.**
  - IDLE: in_ready=1.
    - Accept on in_valid&&in_ready.
    - Non-mul op: result/flags registered on the accept edge, out_valid=1 the following cycle, state stays IDLE.
    - mul op: latch a, b and clear the accumulator on the accept edge; go to MUL with step counter 0.
  - MUL: in_ready=0; in_valid is ignored, and operands need not be held.
    - Each edge performs one shift-add step on a 2·WIDTH accumulator and increments the counter.
    - On the edge completing step WIDTH−1: load {result_hi, result}, update flags, pulse out_valid, return to IDLE.
- No output backpressure: the consumer must take the result in the out_valid cycle.

## Timing
- **Reset** (async, immediate):
  - state=IDLE, counter=0;
  - result=0, result_hi=0;
  - all flags=0;
  - out_valid=0;
  - in_ready=0 while rst is high, 1 in the first cycle after release.
- **Non-mul latency**: 1 cycle (accept edge → out_valid high the next cycle). Throughput is 1 op/cycle back-to-back.
- **Mul latency**: WIDTH cycles. Accept at edge e0 → out_valid high in the cycle after edge e0+WIDTH. in_ready is low for exactly WIDTH cycles.
- **Completion and new accept**: in_ready returns high in the same cycle out_valid is high. An op presented then is accepted on the next edge. For adc/sbc the C flag used is the one just written.
- **Back-to-back adc/sbc**: uses the C from the immediately preceding completed op, with no bubble.
- **Reset mid-mul**: the multiply is abandoned, there is no out_valid, and all reset values apply.
- **Unused out_valid cycles**: out_valid=0; result holds its last value.

## Test plan
- WIDTH=8, add 0xFF+0x01 → the next cycle: out_valid=1, result=0x00, Z=1, C=1, N=0, V=0.
- Following that, adc 0x10+0x20 → result=0x31, C=0; then sbc 0x05−0x05 with C=0 → result=0x00, Z=1, C=0.
- sub 0x80−0x01 → result=0x7F, V=1, C=0, N=0; sub 0x01−0x02 → result=0xFF, C=1, N=1, V=0.
- mul 0xFF×0xFF → in_ready low 8 cycles, out_valid exactly 8 cycles after accept, result=0x01, result_hi=0xFE, C=1, Z=0; a different in_valid op held during busy is accepted only after completion.
- Back-to-back stream: and, or, xor, asr 0x81 (→0xC0, C=1), rol 0x81 (→0x03, C=1), cmp 0x22,0x22 → one out_valid per cycle; cmp sets Z=1 with result still 0x03.
- Assert rst at step 4 of a mul → all outputs 0 asynchronously, no out_valid after release; the next add 0x01+0x01 returns 0x02.
